// File: rtl/bp_commit_trace_arbiter.sv
// bp_commit_trace_arbiter
// Gathers commit packets from several cores into small per-core FIFOs,
// tags each commit with a per-core 30-bit instruction tag, and drains
// the non-empty FIFOs round-robin onto a single valid/ready trace port.
//
// Handshake: trace_v_o is raised whenever any FIFO holds a packet and the
// presented fields stay tied to the selected FIFO head; a packet is
// transferred (and popped) on the rising edge where trace_v_o and
// trace_ready_i are both high. trace_v_o does not depend on trace_ready_i.
module bp_commit_trace_arbiter #(
    parameter int num_core_p       = 2,
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5,
    parameter int fifo_els_p       = 4,
    localparam int core_w_lp       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     freeze_i,
    input  logic [num_core_p-1:0]                    commit_v_i,
    input  logic [num_core_p*vaddr_width_p-1:0]      commit_pc_i,
    input  logic [num_core_p*instr_width_p-1:0]      commit_instr_i,
    input  logic [num_core_p-1:0]                    rd_w_v_i,
    input  logic [num_core_p*reg_addr_width_p-1:0]   rd_addr_i,
    input  logic [num_core_p*dword_width_p-1:0]      rd_data_i,
    output logic                                     trace_v_o,
    input  logic                                     trace_ready_i,
    output logic [core_w_lp-1:0]                     trace_core_o,
    output logic [vaddr_width_p-1:0]                 trace_pc_o,
    output logic [instr_width_p-1:0]                 trace_instr_o,
    output logic                                     trace_rd_w_v_o,
    output logic [reg_addr_width_p-1:0]              trace_rd_addr_o,
    output logic [dword_width_p-1:0]                 trace_rd_data_o,
    output logic [29:0]                              trace_itag_o,
    output logic [num_core_p-1:0]                    overflow_o
);

    localparam int itag_w_lp = 30;
    localparam int ptr_w_lp  = $clog2(fifo_els_p);
    localparam int cnt_w_lp  = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(fifo_els_p);

    typedef struct packed {
        logic [vaddr_width_p-1:0]    pc;
        logic [instr_width_p-1:0]    instr;
        logic                        rd_w_v;
        logic [reg_addr_width_p-1:0] rd_addr;
        logic [dword_width_p-1:0]    rd_data;
        logic [itag_w_lp-1:0]        itag;
    } pkt_t;

    // Architectural state
    logic [num_core_p-1:0][itag_w_lp-1:0] r_itag;
    pkt_t                                 r_mem   [num_core_p][fifo_els_p];
    logic [ptr_w_lp-1:0]                  r_wptr  [num_core_p];
    logic [ptr_w_lp-1:0]                  r_rptr  [num_core_p];
    logic [cnt_w_lp-1:0]                  r_cnt   [num_core_p];
    logic [core_w_lp-1:0]                 r_rr_ptr;
    logic [num_core_p-1:0]                r_overflow;

    // Per-core decode and arbitration wires
    pkt_t                   w_in_pkt [num_core_p];
    logic [num_core_p-1:0]  w_count;
    logic [num_core_p-1:0]  w_full;
    logic [num_core_p-1:0]  w_nonempty;
    logic [num_core_p-1:0]  w_enq;
    logic [num_core_p-1:0]  w_drop;
    logic [num_core_p-1:0]  w_deq;
    logic [core_w_lp-1:0]   w_sel;
    logic [core_w_lp-1:0]   w_rr_nxt;
    logic                   w_fire;
    pkt_t                   w_head;

    // Unpack the flat commit buses and classify each core's commit for this cycle.
    // Full/empty come from the occupancy at the start of the cycle, so a
    // same-cycle pop never makes room for a push into a full FIFO.
    always_comb begin
        for (int c = 0; c < num_core_p; c++) begin
            w_in_pkt[c].pc      = commit_pc_i[c*vaddr_width_p +: vaddr_width_p];
            w_in_pkt[c].instr   = commit_instr_i[c*instr_width_p +: instr_width_p];
            w_in_pkt[c].rd_w_v  = rd_w_v_i[c];
            w_in_pkt[c].rd_addr = rd_addr_i[c*reg_addr_width_p +: reg_addr_width_p];
            w_in_pkt[c].rd_data = rd_data_i[c*dword_width_p +: dword_width_p];
            w_in_pkt[c].itag    = r_itag[c];
            w_count[c]          = commit_v_i[c] & ~freeze_i;
            w_full[c]           = (r_cnt[c] == full_cnt_lp);
            w_nonempty[c]       = (r_cnt[c] != '0);
            w_enq[c]            = w_count[c] & (|w_in_pkt[c].pc) & ~w_full[c];
            w_drop[c]           = w_count[c] & (|w_in_pkt[c].pc) & w_full[c];
        end
    end

    // Pick the first non-empty FIFO at or after the round-robin pointer, wrapping.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        w_sel = '0;
        for (int i = 0; i < num_core_p; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= num_core_p) idx = idx - num_core_p;
            if (!found && w_nonempty[core_w_lp'(idx)]) begin
                found = 1'b1;
                w_sel = core_w_lp'(idx);
            end
        end
    end

    // Next round-robin pointer: one past the core just served, wrapping.
    always_comb begin
        int nxt;
        nxt = int'(w_sel) + 1;
        if (nxt >= num_core_p) nxt = 0;
        w_rr_nxt = core_w_lp'(nxt);
    end

    // Handshake and the one-hot pop that follows from it.
    always_comb begin
        w_fire = trace_v_o & trace_ready_i;
        for (int c = 0; c < num_core_p; c++) begin
            w_deq[c] = w_fire & (w_sel == core_w_lp'(c));
        end
    end

    assign trace_v_o       = |w_nonempty;
    assign w_head          = r_mem[w_sel][r_rptr[w_sel]];
    assign trace_core_o    = w_sel;
    assign trace_pc_o      = w_head.pc;
    assign trace_instr_o   = w_head.instr;
    assign trace_rd_w_v_o  = w_head.rd_w_v;
    assign trace_rd_addr_o = w_head.rd_addr;
    assign trace_rd_data_o = w_head.rd_data;
    assign trace_itag_o    = w_head.itag;
    assign overflow_o      = r_overflow;

    // Pointers, occupancy, itag counters, sticky overflow and the arbitration pointer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < num_core_p; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
            end
            r_itag     <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= '0;
        end else begin
            for (int c = 0; c < num_core_p; c++) begin
                if (w_count[c]) r_itag[c] <= r_itag[c] + itag_w_lp'(1);
                if (w_enq[c])   r_wptr[c] <= r_wptr[c] + ptr_w_lp'(1);
                if (w_deq[c])   r_rptr[c] <= r_rptr[c] + ptr_w_lp'(1);
                if (w_enq[c] && !w_deq[c]) begin
                    r_cnt[c] <= r_cnt[c] + cnt_w_lp'(1);
                end else if (!w_enq[c] && w_deq[c]) begin
                    r_cnt[c] <= r_cnt[c] - cnt_w_lp'(1);
                end
                if (w_drop[c]) r_overflow[c] <= 1'b1;
            end
            if (w_fire) r_rr_ptr <= w_rr_nxt;
        end
    end

    // FIFO storage: no reset needed, contents are only read behind a non-zero count.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < num_core_p; c++) begin
            if (w_enq[c]) r_mem[c][r_wptr[c]] <= w_in_pkt[c];
        end
    end

endmodule

// File: tb/tb_bp_commit_trace_arbiter.sv
// Testbench for bp_commit_trace_arbiter: directed scenarios followed by a
// randomized run, with a queue-based reference model and a negedge monitor.
module tb_bp_commit_trace_arbiter;

    localparam int NC    = 2;
    localparam int VA    = 39;
    localparam int IW    = 32;
    localparam int DW    = 64;
    localparam int RA    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [VA-1:0] pc;
        logic [IW-1:0] instr;
        logic          w_v;
        logic [RA-1:0] addr;
        logic [DW-1:0] data;
        logic [29:0]   itag;
    } pkt_t;

    // Clock / reset and DUT connections
    logic             clk;
    logic             reset_i;
    logic             freeze_i;
    logic [NC-1:0]    commit_v_i;
    logic [NC*VA-1:0] commit_pc_i;
    logic [NC*IW-1:0] commit_instr_i;
    logic [NC-1:0]    rd_w_v_i;
    logic [NC*RA-1:0] rd_addr_i;
    logic [NC*DW-1:0] rd_data_i;
    logic             trace_v_o;
    logic             trace_ready_i;
    logic [0:0]       trace_core_o;
    logic [VA-1:0]    trace_pc_o;
    logic [IW-1:0]    trace_instr_o;
    logic             trace_rd_w_v_o;
    logic [RA-1:0]    trace_rd_addr_o;
    logic [DW-1:0]    trace_rd_data_o;
    logic [29:0]      trace_itag_o;
    logic [NC-1:0]    overflow_o;

    bp_commit_trace_arbiter #(
        .num_core_p(NC), .vaddr_width_p(VA), .instr_width_p(IW),
        .dword_width_p(DW), .reg_addr_width_p(RA), .fifo_els_p(DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i),
        .commit_v_i(commit_v_i), .commit_pc_i(commit_pc_i),
        .commit_instr_i(commit_instr_i), .rd_w_v_i(rd_w_v_i),
        .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
        .trace_v_o(trace_v_o), .trace_ready_i(trace_ready_i),
        .trace_core_o(trace_core_o), .trace_pc_o(trace_pc_o),
        .trace_instr_o(trace_instr_o), .trace_rd_w_v_o(trace_rd_w_v_o),
        .trace_rd_addr_o(trace_rd_addr_o), .trace_rd_data_o(trace_rd_data_o),
        .trace_itag_o(trace_itag_o), .overflow_o(overflow_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counters and scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    pkt_t        exp_q0[$];
    pkt_t        exp_q1[$];
    logic [29:0] m_itag [NC];
    logic [NC-1:0] m_ovf = '0;
    int          m_rr = 0;

    logic [VA-1:0] got_pc[$];
    logic [29:0]   got_itag[$];
    logic [0:0]    got_core[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int msize(input int c);
        return (c == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic pkt_t mhead(input int c);
        return (c == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    // Core that should be presented: first with queued packets from m_rr upward.
    function automatic int msel();
        for (int i = 0; i < NC; i++) begin
            int idx;
            idx = (m_rr + i) % NC;
            if (msize(idx) > 0) return idx;
        end
        return -1;
    endfunction

    // Reference model: advances once per rising edge from the inputs alone.
    always @(posedge clk) begin
        int   sel;
        bit   full_start [NC];
        pkt_t p;
        if (reset_i) begin
            exp_q0.delete();
            exp_q1.delete();
            for (int c = 0; c < NC; c++) m_itag[c] = '0;
            m_ovf = '0;
            m_rr  = 0;
        end else begin
            sel = msel();
            for (int c = 0; c < NC; c++) full_start[c] = (msize(c) == DEPTH);
            if (sel >= 0 && trace_ready_i) begin
                if (sel == 0) void'(exp_q0.pop_front());
                else          void'(exp_q1.pop_front());
                m_rr = (sel + 1) % NC;
            end
            for (int c = 0; c < NC; c++) begin
                if (commit_v_i[c] && !freeze_i) begin
                    p.pc    = commit_pc_i[c*VA +: VA];
                    p.instr = commit_instr_i[c*IW +: IW];
                    p.w_v   = rd_w_v_i[c];
                    p.addr  = rd_addr_i[c*RA +: RA];
                    p.data  = rd_data_i[c*DW +: DW];
                    p.itag  = m_itag[c];
                    if (p.pc != '0) begin
                        if (full_start[c]) m_ovf[c] = 1'b1;
                        else if (c == 0)   exp_q0.push_back(p);
                        else               exp_q1.push_back(p);
                    end
                    m_itag[c] = m_itag[c] + 30'd1;
                end
            end
        end
    end

    // Monitor: compares the presented packet and flags against the model mid-cycle.
    always @(negedge clk) begin
        int   sel;
        pkt_t h;
        if (mon_en) begin
            sel = msel();
            chk("trace_v", 64'(trace_v_o), 64'(sel >= 0));
            chk("overflow", 64'(overflow_o), 64'(m_ovf));
            if (sel >= 0 && trace_v_o) begin
                h = mhead(sel);
                chk("core",    64'(trace_core_o),    64'(sel));
                chk("pc",      64'(trace_pc_o),      64'(h.pc));
                chk("instr",   64'(trace_instr_o),   64'(h.instr));
                chk("rd_w_v",  64'(trace_rd_w_v_o),  64'(h.w_v));
                chk("rd_addr", 64'(trace_rd_addr_o), 64'(h.addr));
                chk("rd_data", trace_rd_data_o,      h.data);
                chk("itag",    64'(trace_itag_o),    64'(h.itag));
            end
            if (trace_v_o && trace_ready_i) begin
                got_pc.push_back(trace_pc_o);
                got_itag.push_back(trace_itag_o);
                got_core.push_back(trace_core_o);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commits();
        commit_v_i = '0;
    endtask

    task automatic set_commit(input int c, input logic [VA-1:0] pc);
        commit_v_i[c]            = 1'b1;
        commit_pc_i[c*VA +: VA]  = pc;
        commit_instr_i[c*IW +: IW] = $urandom;
        rd_w_v_i[c]              = 1'($urandom_range(0, 1));
        rd_addr_i[c*RA +: RA]    = RA'($urandom);
        rd_data_i[c*DW +: DW]    = {$urandom, $urandom};
    endtask

    task automatic got_clear();
        got_pc.delete();
        got_itag.delete();
        got_core.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        clear_commits();
        step();
        reset_i = 1'b0;
    endtask

    task automatic drain(input int n);
        clear_commits();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_i        = 1'b1;
        freeze_i       = 1'b0;
        commit_v_i     = '0;
        commit_pc_i    = '0;
        commit_instr_i = '0;
        rd_w_v_i       = '0;
        rd_addr_i      = '0;
        rd_data_i      = '0;
        trace_ready_i  = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        reset_i = 1'b0;
        chk("reset_v", 64'(trace_v_o), 64'd0);
        chk("reset_ovf", 64'(overflow_o), 64'd0);

        // Single-core flow, one packet per cycle
        got_clear();
        trace_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_commit(0, VA'(64'h8000_0000 + 4 * k));
            step();
        end
        drain(3);
        chk("t1_count", 64'(got_pc.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_pc.size(); k++) begin
            chk("t1_pc", 64'(got_pc[k]), 64'h8000_0000 + 64'(4 * k));
            chk("t1_itag", 64'(got_itag[k]), 64'(k));
        end

        // pc==0 commits consume an itag but produce nothing
        do_reset();
        got_clear();
        set_commit(0, '0);
        step();
        set_commit(0, VA'(64'h8000_0004));
        step();
        drain(3);
        chk("t2_count", 64'(got_pc.size()), 64'd1);
        if (got_itag.size() > 0) chk("t2_itag", 64'(got_itag[0]), 64'd1);

        // Overflow on the fifth commit into a depth-4 FIFO
        do_reset();
        got_clear();
        trace_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_commit(0, VA'(64'h8000_0100 + 4 * k));
            step();
        end
        clear_commits();
        chk("t3_ovf", 64'(overflow_o), 64'd1);
        trace_ready_i = 1'b1;
        drain(6);
        chk("t3_count", 64'(got_itag.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_itag.size(); k++) chk("t3_itag", 64'(got_itag[k]), 64'(k));

        // Round-robin between two loaded cores
        do_reset();
        got_clear();
        trace_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_commit(0, VA'(64'h8000_0200 + 4 * k));
            set_commit(1, VA'(64'h9000_0200 + 4 * k));
            step();
        end
        clear_commits();
        trace_ready_i = 1'b1;
        drain(8);
        chk("t4_count", 64'(got_core.size()), 64'd6);
        for (int k = 0; k < 6 && k < got_core.size(); k++) chk("t4_core", 64'(got_core[k]), 64'(k % 2));

        // Freeze blocks counting; itag wraps from 2^30-1 to 0
        do_reset();
        got_clear();
        trace_ready_i = 1'b1;
        freeze_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_commit(0, VA'(64'h8000_0300 + 4 * k));
            step();
        end
        freeze_i = 1'b0;
        drain(2);
        chk("t5_frozen", 64'(got_pc.size()), 64'd0);
        set_commit(0, VA'(64'h8000_0310));
        step();
        drain(2);
        chk("t5_count", 64'(got_itag.size()), 64'd1);
        if (got_itag.size() > 0) chk("t5_itag", 64'(got_itag[0]), 64'd0);
        got_clear();
        force dut.r_itag = {m_itag[1], 30'h3FFF_FFFF};
        m_itag[0] = 30'h3FFF_FFFF;
        #1;
        release dut.r_itag;
        for (int k = 0; k < 2; k++) begin
            set_commit(0, VA'(64'h8000_0400 + 4 * k));
            step();
        end
        drain(3);
        chk("t5_wrap_count", 64'(got_itag.size()), 64'd2);
        if (got_itag.size() > 1) begin
            chk("t5_wrap_hi", 64'(got_itag[0]), 64'h3FFF_FFFF);
            chk("t5_wrap_lo", 64'(got_itag[1]), 64'd0);
        end

        // Reset with packets queued and overflow set
        do_reset();
        got_clear();
        trace_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_commit(0, VA'(64'h8000_0500 + 4 * k));
            if (k < 2) set_commit(1, VA'(64'h9000_0500 + 4 * k));
            step();
            clear_commits();
        end
        chk("t6_ovf_set", 64'(overflow_o), 64'd1);
        do_reset();
        chk("t6_v", 64'(trace_v_o), 64'd0);
        chk("t6_ovf", 64'(overflow_o), 64'd0);
        trace_ready_i = 1'b1;
        set_commit(0, VA'(64'h8000_0600));
        step();
        drain(2);
        chk("t6_count", 64'(got_itag.size()), 64'd1);
        if (got_itag.size() > 0) chk("t6_itag", 64'(got_itag[0]), 64'd0);

        // Randomized traffic with varying ready pressure and occasional freeze
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_commits();
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 7) == 0) set_commit(c, '0);
                    else set_commit(c, VA'({$urandom, $urandom}) | VA'(1));
                end
            end
            if (cyc < 1000)      trace_ready_i = ($urandom_range(0, 3) != 0);
            else if (cyc < 2000) trace_ready_i = ($urandom_range(0, 3) == 0);
            else                 trace_ready_i = 1'($urandom_range(0, 1));
            freeze_i = ($urandom_range(0, 15) == 0);
            step();
        end
        freeze_i = 1'b0;
        trace_ready_i = 1'b1;
        drain(12);
        chk("final_empty", 64'(trace_v_o), 64'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
